// File: rtl/pkt_fork_n.sv
// ---------------------------------------------------------------------------
// pkt_fork_n
//
// Packet-granular N-way fork for the 512-bit packet stream between
// pattern-matching services. Each packet picks its destination from the
// in_sel sideband sampled on its SOP beat. The beat is then forwarded through
// a single shared output register that is presented to every output, with a
// per-output valid mask. The next beat is accepted only once every targeted
// output has taken the current one.
//
// Optional feature (compile-time macro):
//   PKT_FORK_BROADCAST_EN - an all-ones in_sel on a SOP beat targets every
//                           output. Without the macro, all-ones is simply an
//                           out-of-range select and the packet is dropped.
//
// Parameters:
//   NUM_OUT    - number of output ports (2..8)
//   DATA_BITS  - beat width
//   EMPTY_BITS - width of the empty-byte count
//   SEL_BITS   - width of in_sel; 2**SEL_BITS must exceed NUM_OUT
//
// Ports:
//   Clk, Rst_n       - clock, asynchronous active-low reset
//   in_data          - input beat
//   in_valid         - input beat valid
//   in_ready         - input beat may transfer this cycle
//   in_sop, in_eop   - packet start / end markers
//   in_empty         - empty bytes on the EOP beat
//   in_sel           - destination index, sampled on SOP beats only
//   out_data         - registered beat, shared by all outputs
//   out_sop, out_eop - shared markers
//   out_empty        - shared empty-byte count
//   out_valid        - per-output valid (the pending mask)
//   out_ready        - per-output ready
//   stats_out_pkt    - per-output count of delivered EOP beats (32b each)
//   stats_out_pkt_s  - per-output count of delivered SOP beats (32b each)
//   stats_drop_pkt   - packets discarded for an invalid select
//   stats_proto_err  - stray non-SOP beats and SOPs arriving mid-packet
// ---------------------------------------------------------------------------
`default_nettype none

module pkt_fork_n #(
    parameter int NUM_OUT    = 2,
    parameter int DATA_BITS  = 512,
    parameter int EMPTY_BITS = 6,
    parameter int SEL_BITS   = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,

    input  logic [DATA_BITS-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [EMPTY_BITS-1:0]   in_empty,
    input  logic [SEL_BITS-1:0]     in_sel,

    output logic [DATA_BITS-1:0]    out_data,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [EMPTY_BITS-1:0]   out_empty,
    output logic [NUM_OUT-1:0]      out_valid,
    input  logic [NUM_OUT-1:0]      out_ready,

    output logic [NUM_OUT*32-1:0]   stats_out_pkt,
    output logic [NUM_OUT*32-1:0]   stats_out_pkt_s,
    output logic [31:0]             stats_drop_pkt,
    output logic [31:0]             stats_proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // between packets, waiting for SOP
        ST_FWD  = 2'd1,   // inside a packet being forwarded with fwd_mask
        ST_DROP = 2'd2    // inside a packet being discarded
    } state_t;

    state_t               state;
    logic [NUM_OUT-1:0]   fwd_mask;   // destination of the packet in flight
    logic [NUM_OUT-1:0]   pending;    // outputs that still owe an accept
    logic                 run;        // low in reset, high from first edge after

    logic [NUM_OUT-1:0]   accept;     // outputs taking the current beat
    logic [NUM_OUT-1:0]   hold;       // pending outputs not accepting
    logic                 xfer;       // input beat transfers this cycle

    logic                 sel_ok;     // in_sel names a real output
    logic                 sel_bcast;  // in_sel requests broadcast
    logic [NUM_OUT-1:0]   sel_onehot;
    logic [NUM_OUT-1:0]   sel_mask;   // destination mask for a SOP beat

    // -----------------------------------------------------------------------
    // Output-stage handshake
    // -----------------------------------------------------------------------
    assign accept    = pending & out_ready;
    assign hold      = pending & ~out_ready;
    assign out_valid = pending;

    // The stage is free once every pending output is either done or taking
    // the beat right now, so a drained beat and a new load share one cycle.
    // in_ready looks only at the output side, never at in_valid.
    assign in_ready  = run && (hold == '0);
    assign xfer      = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Destination decode for SOP beats
    // -----------------------------------------------------------------------
    assign sel_ok     = (in_sel < SEL_BITS'(NUM_OUT));
    assign sel_onehot = NUM_OUT'(1) << in_sel;

`ifdef PKT_FORK_BROADCAST_EN
    assign sel_bcast  = &in_sel;
`else
    assign sel_bcast  = 1'b0;
`endif

    // Out-of-range selects never load, so the all-ones branch is only
    // reached for a broadcast request.
    assign sel_mask   = sel_ok ? sel_onehot : {NUM_OUT{1'b1}};

    // -----------------------------------------------------------------------
    // Control FSM, output register and packet-level counters
    // -----------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all of them see the
    // pre-edge values of each other; mixing in = would make the result
    // depend on statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state           <= ST_IDLE;
            fwd_mask        <= '0;
            pending         <= '0;
            run             <= 1'b0;
            // NOTE: the beat register is reset as well because out_data and
            // the markers must read as zero in reset, even though out_valid
            // already qualifies them.
            out_data        <= '0;
            out_sop         <= 1'b0;
            out_eop         <= 1'b0;
            out_empty       <= '0;
            stats_drop_pkt  <= '0;
            stats_proto_err <= '0;
        end else begin
            run     <= 1'b1;
            // Accepted outputs drop out of the mask; a load below overrides
            // this, which is safe because a load needs hold == 0.
            pending <= hold;

            if (xfer) begin
                if (in_sop) begin
                    // A SOP inside a packet means the previous EOP never
                    // came: flag it and restart as if we were in IDLE. The
                    // truncated packet gets no EOP delivered, so it is never
                    // counted as a delivered packet.
                    if (state != ST_IDLE) begin
                        stats_proto_err <= stats_proto_err + 32'd1;
                    end

                    if (sel_ok || sel_bcast) begin
                        fwd_mask  <= sel_mask;
                        pending   <= sel_mask;
                        out_data  <= in_data;
                        out_sop   <= 1'b1;
                        out_eop   <= in_eop;
                        out_empty <= in_empty;
                        state     <= in_eop ? ST_IDLE : ST_FWD;
                    end else begin
                        stats_drop_pkt <= stats_drop_pkt + 32'd1;
                        state          <= in_eop ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    case (state)
                        ST_FWD: begin
                            pending   <= fwd_mask;
                            out_data  <= in_data;
                            out_sop   <= 1'b0;
                            out_eop   <= in_eop;
                            out_empty <= in_empty;
                            if (in_eop) begin
                                state <= ST_IDLE;
                            end
                        end
                        ST_DROP: begin
                            if (in_eop) begin
                                state <= ST_IDLE;
                            end
                        end
                        default: begin
                            // Body beat with no packet open: discard it.
                            stats_proto_err <= stats_proto_err + 32'd1;
                            state           <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-output delivery counters
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_stats
        logic [31:0] eop_cnt;
        logic [31:0] sop_cnt;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                eop_cnt <= '0;
                sop_cnt <= '0;
            end else if (accept[i]) begin
                if (out_eop) begin
                    eop_cnt <= eop_cnt + 32'd1;
                end
                if (out_sop) begin
                    sop_cnt <= sop_cnt + 32'd1;
                end
            end
        end

        assign stats_out_pkt[i*32 +: 32]   = eop_cnt;
        assign stats_out_pkt_s[i*32 +: 32] = sop_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_pkt_fork_n.sv
// ---------------------------------------------------------------------------
// tb_pkt_fork_n
//
// Self-checking bench for pkt_fork_n with NUM_OUT = 4. Every accepted input
// beat pushes its expected copy onto the queue of each output it targets; a
// negedge monitor pops and compares whenever an output handshakes. Scenario
// tasks add inline checks for latency, backpressure, stats and reset.
// Define PKT_FORK_BROADCAST_EN for both files to exercise broadcast.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pkt_fork_n;

    localparam int NUM_OUT    = 4;
    localparam int DATA_BITS  = 512;
    localparam int EMPTY_BITS = 6;
    localparam int SEL_BITS   = 4;

    typedef struct {
        logic [DATA_BITS-1:0]  data;
        logic                  sop;
        logic                  eop;
        logic [EMPTY_BITS-1:0] empty;
    } beat_t;

    logic                    Clk;
    logic                    Rst_n;
    logic [DATA_BITS-1:0]    in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sop;
    logic                    in_eop;
    logic [EMPTY_BITS-1:0]   in_empty;
    logic [SEL_BITS-1:0]     in_sel;
    logic [DATA_BITS-1:0]    out_data;
    logic                    out_sop;
    logic                    out_eop;
    logic [EMPTY_BITS-1:0]   out_empty;
    logic [NUM_OUT-1:0]      out_valid;
    logic [NUM_OUT-1:0]      out_ready;
    logic [NUM_OUT*32-1:0]   stats_out_pkt;
    logic [NUM_OUT*32-1:0]   stats_out_pkt_s;
    logic [31:0]             stats_drop_pkt;
    logic [31:0]             stats_proto_err;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t sb [NUM_OUT][$];
    int    exp_pkt   [NUM_OUT];
    int    exp_pkt_s [NUM_OUT];
    beat_t mon_b;

    pkt_fork_n #(
        .NUM_OUT    (NUM_OUT),
        .DATA_BITS  (DATA_BITS),
        .EMPTY_BITS (EMPTY_BITS),
        .SEL_BITS   (SEL_BITS)
    ) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sop          (in_sop),
        .in_eop          (in_eop),
        .in_empty        (in_empty),
        .in_sel          (in_sel),
        .out_data        (out_data),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_empty       (out_empty),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .stats_out_pkt   (stats_out_pkt),
        .stats_out_pkt_s (stats_out_pkt_s),
        .stats_drop_pkt  (stats_drop_pkt),
        .stats_proto_err (stats_proto_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_BITS-1:0] mk(input int id);
        logic [31:0] w;
        w = 32'(id) ^ 32'h5A5A_0000;
        return {16{w}};
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard monitor: outputs are sampled on the falling edge, where the
    // handshake that completes on the next rising edge is already settled.
    // -----------------------------------------------------------------------
    always @(negedge Clk) begin
        if (Rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    n_vec++;
                    if (sb[i].size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_beat out%0d: got data[31:0]=%h sop=%b eop=%b, required no beat",
                                 i, out_data[31:0], out_sop, out_eop);
                    end else begin
                        mon_b = sb[i].pop_front();
                        if (out_data !== mon_b.data || out_sop !== mon_b.sop ||
                            out_eop !== mon_b.eop || out_empty !== mon_b.empty) begin
                            n_err++;
                            $display("FAIL beat out%0d: got d=%h s=%b e=%b emp=%0d, required d=%h s=%b e=%b emp=%0d",
                                     i, out_data[31:0], out_sop, out_eop, out_empty,
                                     mon_b.data[31:0], mon_b.sop, mon_b.eop, mon_b.empty);
                        end
                        if (mon_b.eop) exp_pkt[i]++;
                        if (mon_b.sop) exp_pkt_s[i]++;
                    end
                end
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for it to transfer, and push its
    // expected copy to every output in dest.
    task automatic send_beat(input int id, input logic sop, input logic eop,
                             input logic [EMPTY_BITS-1:0] empty,
                             input logic [SEL_BITS-1:0] sel,
                             input logic [NUM_OUT-1:0] dest);
        int    waited;
        logic  rdy;
        beat_t b;
        in_data  = mk(id);
        in_sop   = sop;
        in_eop   = eop;
        in_empty = empty;
        in_sel   = sel;
        in_valid = 1'b1;
        waited   = 0;
        rdy      = 1'b0;
        while (!rdy && waited < 100) begin
            @(negedge Clk);
            rdy = in_ready;
            @(posedge Clk);
            waited++;
        end
        if (!rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout id=%0d: in_ready stayed %b, required 1", id, in_ready);
        end else begin
            b.data  = mk(id);
            b.sop   = sop;
            b.eop   = eop;
            b.empty = empty;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (dest[i]) sb[i].push_back(b);
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset;
        #3;
        n_vec++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: got out_valid=%b in_ready=%b, required 0000 0", out_valid, in_ready);
        end
        n_vec++;
        if (out_data !== '0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_empty !== '0) begin
            n_err++;
            $display("FAIL reset_beat: got d=%h s=%b e=%b emp=%0d, required all 0",
                     out_data[31:0], out_sop, out_eop, out_empty);
        end
        n_vec++;
        if (stats_out_pkt !== '0 || stats_out_pkt_s !== '0 || stats_drop_pkt !== 32'd0 ||
            stats_proto_err !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stats: got nonzero counters, required all 0");
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: got %b, required 0", in_ready);
        end
        @(posedge Clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_edge: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_unicast;
        logic [NUM_OUT-1:0] m;
        for (int s = 0; s < NUM_OUT; s++) begin
            m = NUM_OUT'(1) << s;
            send_beat(100 + s*10, 1'b1, 1'b0, 6'd0, SEL_BITS'(s), m);
            n_vec++;
            if (out_valid !== m) begin
                n_err++;
                $display("FAIL latency sel=%0d: got out_valid=%b, required %b", s, out_valid, m);
            end
            send_beat(101 + s*10, 1'b0, 1'b0, 6'd0, SEL_BITS'(s), m);
            send_beat(102 + s*10, 1'b0, 1'b1, EMPTY_BITS'(s + 1), SEL_BITS'(s), m);
        end
        idle(3);
        for (int i = 0; i < NUM_OUT; i++) begin
            n_vec++;
            if (stats_out_pkt[i*32 +: 32] !== 32'd1 || stats_out_pkt_s[i*32 +: 32] !== 32'd1) begin
                n_err++;
                $display("FAIL unicast_stats out%0d: got eop=%0d sop=%0d, required 1 1",
                         i, stats_out_pkt[i*32 +: 32], stats_out_pkt_s[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_drop;
        send_beat(200, 1'b1, 1'b0, 6'd0, 4'd5, 4'b0000);
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL drop_sop: got out_valid=%b, required 0000", out_valid);
        end
        send_beat(201, 1'b0, 1'b1, 6'd7, 4'd0, 4'b0000);
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL drop_eop: got out_valid=%b, required 0000", out_valid);
        end
        send_beat(210, 1'b1, 1'b0, 6'd0, 4'd1, 4'b0010);
        send_beat(211, 1'b0, 1'b1, 6'd9, 4'd3, 4'b0010);
        idle(3);
        n_vec++;
        if (stats_drop_pkt !== 32'd1) begin
            n_err++;
            $display("FAIL drop_count: got %0d, required 1", stats_drop_pkt);
        end
        n_vec++;
        if (stats_out_pkt[1*32 +: 32] !== 32'd2) begin
            n_err++;
            $display("FAIL drop_next_pkt: got %0d, required 2", stats_out_pkt[1*32 +: 32]);
        end
    endtask

    task automatic test_back_to_back;
        logic pend;
        logic exp_rdy;
        logic rdy;
        int   sent;
        beat_t b;
        pend     = 1'b0;
        sent     = 0;
        in_sop   = 1'b1;
        in_eop   = 1'b1;
        in_sel   = 4'd0;
        in_empty = 6'd3;
        in_data  = mk(300);
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            out_ready[0] = (c % 2 == 0);
            @(negedge Clk);
            exp_rdy = !(pend && !out_ready[0]);
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL b2b_ready cycle %0d: got %b, required %b", c, in_ready, exp_rdy);
            end
            rdy = in_ready;
            @(posedge Clk);
            if (rdy) begin
                b.data = mk(300 + sent); b.sop = 1'b1; b.eop = 1'b1; b.empty = 6'd3;
                sb[0].push_back(b);
                sent++;
                pend = 1'b1;
            end else if (pend && out_ready[0]) begin
                pend = 1'b0;
            end
            #1;
            in_data = mk(300 + sent);
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        idle(3);
        n_vec++;
        if (sent != 6) begin
            n_err++;
            $display("FAIL b2b_count: got %0d beats accepted, required 6", sent);
        end
    endtask

    task automatic test_proto;
        send_beat(500, 1'b0, 1'b0, 6'd0, 4'd2, 4'b0000);
        n_vec++;
        if (stats_proto_err !== 32'd1 || out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL proto_stray: got err=%0d out_valid=%b, required 1 0000", stats_proto_err, out_valid);
        end
        send_beat(510, 1'b1, 1'b0, 6'd0, 4'd2, 4'b0100);
        send_beat(520, 1'b1, 1'b0, 6'd0, 4'd2, 4'b0100);
        send_beat(521, 1'b0, 1'b0, 6'd0, 4'd0, 4'b0100);
        send_beat(522, 1'b0, 1'b1, 6'd11, 4'd0, 4'b0100);
        idle(3);
        n_vec++;
        if (stats_proto_err !== 32'd2) begin
            n_err++;
            $display("FAIL proto_count: got %0d, required 2", stats_proto_err);
        end
        n_vec++;
        if (stats_out_pkt[2*32 +: 32] !== 32'd2 || stats_out_pkt_s[2*32 +: 32] !== 32'd3) begin
            n_err++;
            $display("FAIL proto_stats: got eop=%0d sop=%0d, required 2 3",
                     stats_out_pkt[2*32 +: 32], stats_out_pkt_s[2*32 +: 32]);
        end
    endtask

    task automatic test_broadcast;
`ifdef PKT_FORK_BROADCAST_EN
        out_ready = 4'b0111;
        send_beat(400, 1'b1, 1'b1, 6'd5, 4'hF, 4'b1111);
        n_vec++;
        if (out_valid !== 4'b1111) begin
            n_err++;
            $display("FAIL bcast_valid: got %b, required 1111", out_valid);
        end
        for (int c = 0; c < 2; c++) begin
            idle(1);
            n_vec++;
            if (out_valid !== 4'b1000 || in_ready !== 1'b0 || out_data !== mk(400) || out_empty !== 6'd5) begin
                n_err++;
                $display("FAIL bcast_hold %0d: got valid=%b rdy=%b d=%h, required 1000 0 %h",
                         c, out_valid, in_ready, out_data[31:0], mk(400) >> (DATA_BITS - 32));
            end
        end
        out_ready = 4'hF;
        idle(1);
        n_vec++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bcast_drain: got valid=%b rdy=%b, required 0000 1", out_valid, in_ready);
        end
        idle(2);
        for (int i = 0; i < NUM_OUT; i++) begin
            n_vec++;
            if (stats_out_pkt[i*32 +: 32] !== 32'(exp_pkt[i])) begin
                n_err++;
                $display("FAIL bcast_stats out%0d: got %0d, required %0d", i, stats_out_pkt[i*32 +: 32], exp_pkt[i]);
            end
        end
        n_vec++;
        if (stats_drop_pkt !== 32'd1) begin
            n_err++;
            $display("FAIL bcast_not_drop: got %0d, required 1", stats_drop_pkt);
        end
`else
        send_beat(400, 1'b1, 1'b1, 6'd5, 4'hF, 4'b0000);
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL allones_drop_valid: got %b, required 0000", out_valid);
        end
        idle(2);
        n_vec++;
        if (stats_drop_pkt !== 32'd2) begin
            n_err++;
            $display("FAIL allones_drop_count: got %0d, required 2", stats_drop_pkt);
        end
`endif
    endtask

    task automatic test_reset_mid;
        out_ready = 4'b1110;
        send_beat(600, 1'b1, 1'b0, 6'd0, 4'd0, 4'b0000);
        n_vec++;
        if (out_valid !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_pending: got %b, required 0001", out_valid);
        end
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL mid_reset_out: got valid=%b rdy=%b d=%h, required 0000 0 0",
                     out_valid, in_ready, out_data[31:0]);
        end
        n_vec++;
        if (stats_out_pkt !== '0 || stats_out_pkt_s !== '0 || stats_drop_pkt !== 32'd0 ||
            stats_proto_err !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_stats: got drop=%0d err=%0d, required all 0",
                     stats_drop_pkt, stats_proto_err);
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            sb[i].delete();
            exp_pkt[i]   = 0;
            exp_pkt_s[i] = 0;
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 4'hF;
        send_beat(700, 1'b1, 1'b0, 6'd0, 4'd3, 4'b1000);
        send_beat(701, 1'b0, 1'b1, 6'd2, 4'd0, 4'b1000);
        idle(3);
        for (int i = 0; i < NUM_OUT; i++) begin
            n_vec++;
            if (stats_out_pkt[i*32 +: 32] !== ((i == 3) ? 32'd1 : 32'd0) ||
                stats_out_pkt_s[i*32 +: 32] !== ((i == 3) ? 32'd1 : 32'd0)) begin
                n_err++;
                $display("FAIL post_reset_stats out%0d: got eop=%0d sop=%0d, required %0d",
                         i, stats_out_pkt[i*32 +: 32], stats_out_pkt_s[i*32 +: 32], (i == 3) ? 1 : 0);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        Rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_empty  = '0;
        in_sel    = '0;
        out_ready = 4'hF;
        for (int i = 0; i < NUM_OUT; i++) begin
            exp_pkt[i]   = 0;
            exp_pkt_s[i] = 0;
        end

        test_reset();
        test_unicast();
        test_drop();
        test_back_to_back();
        test_proto();
        test_broadcast();
        test_reset_mid();

        for (int i = 0; i < NUM_OUT; i++) begin
            n_vec++;
            if (sb[i].size() != 0) begin
                n_err++;
                $display("FAIL leftover out%0d: got %0d undelivered beats, required 0", i, sb[i].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_fork_n.md
# pkt_fork_n

N-way packet-granular fork for the 512-bit packet stream between pattern-matching services. It generalises the fixed two-way nocheck/check split into `NUM_OUT` outputs, with per-packet destination selection and optional broadcast. Each packet's destination comes from a sideband select sampled on its SOP beat. The block sits directly behind `non_fast_pattern_client` (and any later matcher), feeding downstream channel FIFOs.

## Interface
- `NUM_OUT`, 2: number of output ports, 2..8.
- `DATA_BITS`, 512: beat width.
- `EMPTY_BITS`, 6: width of the empty-byte count.
- `SEL_BITS`, 4: width of the select sideband; must satisfy 2^SEL_BITS > NUM_OUT.
- `Clk`  in  1  single clock for the block.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_BITS  input beat.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input may transfer this cycle.
- `in_sop`, `in_eop`  in  1 each  packet start / end markers.
- `in_empty`  in  EMPTY_BITS  empty bytes on the EOP beat.
- `in_sel`  in  SEL_BITS  destination index; sampled only on SOP beats.
- `out_data`  out  DATA_BITS  shared registered beat, valid on every output.
- `out_sop`, `out_eop`  out  1 each  shared markers.
- `out_empty`  out  EMPTY_BITS  shared empty-byte count.
- `out_valid`  out  NUM_OUT  per-output valid.
- `out_ready`  in  NUM_OUT  per-output ready.
- `stats_out_pkt`  out  NUM_OUT*32  per-output count of delivered EOP beats.
- `stats_out_pkt_s`  out  NUM_OUT*32  per-output count of delivered SOP beats.
- `stats_drop_pkt`  out  32  packets dropped because of an invalid select.
- `stats_proto_err`  out  32  protocol violations.

## Operation
- An input beat transfers when `in_valid && in_ready`.
- Control FSM states:
  - **IDLE**: waits for a SOP beat.
  - **FWD**: inside a packet; a destination mask is latched.
  - **DROP**: inside a packet that is being discarded.
- SOP beat accepted in IDLE:
  - `in_sel < NUM_OUT`: destination mask = one-hot(`in_sel`). The beat is loaded into the output stage. The FSM goes to FWD, or stays in IDLE if `in_eop` is also set.
  - Otherwise: the beat is discarded and `stats_drop_pkt` increments. The FSM goes to DROP, or stays in IDLE if `in_eop` is also set.
- Non-SOP beat in FWD: loaded into the output stage with the latched mask. An EOP beat returns the FSM to IDLE.
- Non-SOP beat in DROP: discarded. An EOP beat returns the FSM to IDLE.
- Non-SOP beat in IDLE: discarded; `stats_proto_err` increments.
- SOP beat in FWD or DROP (missing EOP): `stats_proto_err` increments. The beat is then handled as a SOP in IDLE. The previous packet is left truncated and is not counted in `stats_out_pkt`.
- Output stage:
  - One register holding the beat plus a `pending` mask; `out_valid = pending`.
  - `pending[i]` clears on any cycle where `out_valid[i] && out_ready[i]`.
  - The stage is free when `pending == 0`, or when every pending bit is being accepted in the current cycle.
  - `in_ready = stage free`. It never depends combinationally on `in_valid`.
- Stats:
  - `stats_out_pkt[i]` increments when output i accepts a beat with `out_eop` set.
  - `stats_out_pkt_s[i]` increments when output i accepts a beat with `out_sop` set.
  - All counters are 32 bits and wrap from 0xFFFFFFFF to 0.

## Timing
- Latency: an input beat accepted on cycle t appears on `out_*` at t+1.
- Throughput: 1 beat/cycle while all targeted `out_ready` bits are held high.
- Backpressure: while any `pending` bit is unaccepted, `in_ready = 0`. The output register holds `data`, `sop`, `eop` and `empty` stable.
- A beat and its consumption may occur in the same cycle: the stage is reloaded and `pending` is set to the new mask.
- Reset is asynchronous and active-low. It forces:
  - FSM to IDLE, `pending = 0`, `out_valid = 0`, `in_ready = 0` while `Rst_n` is low.
  - `out_data`, `out_sop`, `out_eop` and `out_empty` to 0.
  - All stats counters to 0.
- `in_ready` rises on the first clock edge after `Rst_n` deasserts. Reset mid-packet abandons the packet with no stats update.

## Configuration
- `PKT_FORK_BROADCAST_EN`
  - Defined: `in_sel` = all-ones (2^SEL_BITS−1) on a SOP beat sets the mask to all NUM_OUT bits. Each output drains independently, and the next beat waits until every output has accepted. Per-output stats count normally; this is not a drop.
  - Undefined: all-ones is just an invalid select and the packet is dropped.

## Test plan
- NUM_OUT=4: 3-beat packets with sel 0,1,2,3, all ready high → each packet appears only on its output, latency 1, `stats_out_pkt` = {1,1,1,1}, `stats_out_pkt_s` = {1,1,1,1}.
- sel=5 with NUM_OUT=4, 2-beat packet followed by a valid sel=1 packet → no `out_valid` for the first packet, `stats_drop_pkt`=1, second packet delivered on output 1.
- Single-beat packet (sop=eop=1) every cycle to sel=0 with `out_ready[0]` toggling 1,0,1,0 → no beat lost or duplicated, `in_ready` low exactly in the stalled cycles.
- Mid-stream beats without SOP, then SOP, SOP (no EOP), EOP → `stats_proto_err`=2 (stray beat + missing EOP), the second packet is delivered intact.
- With `PKT_FORK_BROADCAST_EN`, sel=0xF and NUM_OUT=3, where output 2 accepts 2 cycles late → the beat is held until output 2 accepts, then `stats_out_pkt` = {1,1,1}.
- `Rst_n` pulsed low mid-packet with `pending`=0b01 → `out_valid`=0 immediately and all stats read 0. A fresh packet after reset is delivered correctly.
